// File: rtl/cbus_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// cbus_axi_bridge_pkg
//
// Shared types for the data-cache side bus (cbus) and the AXI4 memory port.
//
// Contents:
//   AXI_ID_W        width of the AXI ID fields carried in axi_req_t
//   AXI_BURST_INCR  AXI incrementing burst encoding
//   AXI_RESP_OKAY   AXI OKAY response encoding
//   msize_t         cache access size, encoded as the AXI AxSIZE value
//   mlen_t          burst length, encoded as beats-1 (MLEN1 = 0 ... MLEN16 = 15)
//   cbus_req_t      cache -> bridge request
//   cbus_resp_t     bridge -> cache response
//   axi_req_t       master-driven AXI4 signals (AR, AW, W, rready, bready)
//   axi_resp_t      slave-driven AXI4 signals (arready, awready, wready, R, B)
//   axi_len()       widens an mlen_t into an 8-bit AxLEN field
// -----------------------------------------------------------------------------
package cbus_axi_bridge_pkg;

    localparam int         AXI_ID_W       = 4;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Values equal the AXI AxSIZE encoding so they can be forwarded unchanged.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    // Beats minus one, i.e. the low nibble of AxLEN.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
        MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
        MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
        MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
    } mlen_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef struct packed {
        // AR channel
        logic [AXI_ID_W-1:0] arid;
        logic [31:0]         araddr;
        logic [7:0]          arlen;
        logic [2:0]          arsize;
        logic [1:0]          arburst;
        logic                arvalid;
        // R channel
        logic                rready;
        // AW channel
        logic [AXI_ID_W-1:0] awid;
        logic [31:0]         awaddr;
        logic [7:0]          awlen;
        logic [2:0]          awsize;
        logic [1:0]          awburst;
        logic                awvalid;
        // W channel
        logic [31:0]         wdata;
        logic [3:0]          wstrb;
        logic                wlast;
        logic                wvalid;
        // B channel
        logic                bready;
    } axi_req_t;

    // Only one transaction is ever outstanding with a fixed ID, so the
    // returned rid/bid carry no information and are not modelled.
    typedef struct packed {
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
    } axi_resp_t;

    function automatic logic [7:0] axi_len(input mlen_t len);
        return {4'b0000, len};
    endfunction

endpackage

// File: rtl/cbus_axi_bridge.sv
// -----------------------------------------------------------------------------
// cbus_axi_bridge
//
// Converts each data-cache request (line fill, write-back, uncached access)
// into exactly one AXI4 INCR burst and returns per-beat responses to the cache.
// One transaction is in flight at a time.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   creq       cache request (valid, is_write, size, addr, strobe, data, len)
//   cresp      cache response (ready, last, data)
//   axi_req    AXI4 master outputs (AR, AW, W channels, rready, bready)
//   axi_resp   AXI4 slave inputs (arready, awready, wready, R and B channels)
//   bus_error  sticky flag, set by any non-OKAY rresp or bresp
//   dbg_state  current FSM state: 0 IDLE, 1 AR, 2 R, 3 AW, 4 W, 5 B
//
// Handshake semantics: every AXI channel transfers on a cycle where its
// valid and ready are both high at the rising clock edge; a raised valid is
// held, with its payload stable, until that transfer. On the cache side
// cresp.ready marks one accepted/returned data beat and cresp.last marks the
// end of the transaction; the cache holds creq stable while creq.valid is
// high, advances write data only after cresp.ready, and drops creq.valid in
// the cycle after cresp.last.
//
// Address/control outputs come from registers; write data and strobes pass
// straight through from creq.
// -----------------------------------------------------------------------------
module cbus_axi_bridge
    import cbus_axi_bridge_pkg::*;
#(
    parameter int              ID_W   = AXI_ID_W,
    parameter logic [ID_W-1:0] AXI_ID = 4'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output axi_req_t   axi_req,
    input  axi_resp_t  axi_resp,
    output logic       bus_error,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } state_e;

    state_e      state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    msize_t      size_q,    size_d;
    mlen_t       len_q,     len_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        berr_q,    berr_d;

    logic        last_beat;

    // The beat counter, not rlast, decides where a read burst ends.
    assign last_beat = (cnt_q == len_q);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            size_q    <= MSIZE1;
            len_q     <= MLEN1;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            berr_q    <= berr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        berr_d    = berr_q;

        cresp     = '0;

        axi_req         = '0;
        axi_req.arid    = AXI_ID_W'(AXI_ID);
        axi_req.araddr  = addr_q;
        axi_req.arlen   = axi_len(len_q);
        axi_req.arsize  = size_q;
        axi_req.arburst = AXI_BURST_INCR;
        axi_req.arvalid = arvalid_q;
        axi_req.awid    = AXI_ID_W'(AXI_ID);
        axi_req.awaddr  = addr_q;
        axi_req.awlen   = axi_len(len_q);
        axi_req.awsize  = size_q;
        axi_req.awburst = AXI_BURST_INCR;
        axi_req.awvalid = awvalid_q;
        axi_req.wdata   = creq.data;
        axi_req.wstrb   = creq.strobe;

        case (state_q)
            S_IDLE: begin
                // The AR/AW branch taken here is what records is_write.
                if (creq.valid) begin
                    addr_d = creq.addr;
                    size_d = creq.size;
                    len_d  = creq.len;
                    cnt_d  = '0;
                    if (creq.is_write) begin
                        state_d   = S_AW;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            S_AR: begin
                if (axi_resp.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end
            end

            S_R: begin
                axi_req.rready = 1'b1;
                if (axi_resp.rvalid) begin
                    cresp.ready = 1'b1;
                    cresp.data  = axi_resp.rdata;
                    cnt_d       = cnt_q + 4'd1;
                    if (axi_resp.rresp != AXI_RESP_OKAY) begin
                        berr_d = 1'b1;
                    end
                    if (last_beat) begin
                        cresp.last = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            S_AW: begin
                if (axi_resp.awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_W;
                end
            end

            S_W: begin
                axi_req.wvalid = 1'b1;
                axi_req.wlast  = last_beat;
                // Beat acceptance is reported in the handshake cycle itself so
                // the cache can present the next word for the following edge.
                if (axi_resp.wready) begin
                    cresp.ready = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                    if (last_beat) begin
                        state_d = S_B;
                    end
                end
            end

            S_B: begin
                axi_req.bready = 1'b1;
                // Writes complete only once the slave has committed the data.
                if (axi_resp.bvalid) begin
                    cresp.last = 1'b1;
                    state_d    = S_IDLE;
                    if (axi_resp.bresp != AXI_RESP_OKAY) begin
                        berr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_error = berr_q;
    assign dbg_state = state_q;

    // The slave's rlast must agree with the burst length we requested.
    rlast_matches_counter: assert property (
        @(posedge clk) disable iff (!resetn)
        (state_q == S_R && axi_resp.rvalid) |-> (axi_resp.rlast == last_beat)
    );

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_cbus_axi_bridge
//
// Bench for cbus_axi_bridge. A cache-side driver and an AXI slave model are
// written as tasks that advance one clock at a time; inputs change 1 ns after
// the rising edge and outputs are sampled on the falling edge. Expected read
// and write data words go into exp_q when a transaction is launched and are
// popped as the bridge produces each beat.
// -----------------------------------------------------------------------------
module tb_cbus_axi_bridge;
    import cbus_axi_bridge_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    axi_req_t   axi_req;
    axi_resp_t  axi_resp;
    logic       bus_error;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    cbus_axi_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .creq      (creq),
        .cresp     (cresp),
        .axi_req   (axi_req),
        .axi_resp  (axi_resp),
        .bus_error (bus_error),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    logic        exp_berr;
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [2:0] ST_IDLE = 3'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops the next expected word and compares it with an observed one.
    task automatic sb_compare(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_underflow"}, 64'd0, 64'd1);
        end else begin
            check_eq(tag, got, exp_q.pop_front());
        end
    endtask

    function automatic logic [4:0] valid_ready_bits();
        return {axi_req.arvalid, axi_req.awvalid, axi_req.wvalid,
                axi_req.rready, axi_req.bready};
    endfunction

    // ------------------------------------------------------------------
    // Driver: read burst (AR handshake, then len+1 R beats of base+i)
    // abort_beat >= 0 pulses resetn during that beat and abandons the burst.
    // ------------------------------------------------------------------
    task automatic do_read(input logic [31:0] addr, input msize_t size, input logic [3:0] len,
                           input logic [31:0] base, input bit gaps, input logic [1:0] rr,
                           input int abort_beat);
        int stall;
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(base + 32'(i));

        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.addr     = addr;
        creq.size     = size;
        creq.len      = mlen_t'(len);
        creq.strobe   = 4'hF;
        @(negedge clk);
        check_eq("rd_idle_arvalid", axi_req.arvalid, 1'b0);
        step();
        @(negedge clk);
        check_eq("rd_arvalid_lat", axi_req.arvalid, 1'b1);
        check_eq("rd_araddr", axi_req.araddr, addr);
        check_eq("rd_arlen", axi_req.arlen, {4'b0, len});
        check_eq("rd_arsize", axi_req.arsize, size);
        check_eq("rd_arburst", axi_req.arburst, 2'b01);
        check_eq("rd_arid", axi_req.arid, 4'd0);
        check_eq("rd_ar_cresp", cresp, '0);

        stall = gaps ? $urandom_range(0, 2) : 0;
        for (int s = 0; s < stall; s++) begin
            step();
            @(negedge clk);
            check_eq("rd_arvalid_hold", axi_req.arvalid, 1'b1);
            check_eq("rd_araddr_hold", axi_req.araddr, addr);
        end
        axi_resp.arready = 1'b1;
        step();
        axi_resp.arready = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            stall = gaps ? $urandom_range(0, 3) : 0;
            axi_resp.rvalid = 1'b0;
            for (int g = 0; g < stall; g++) begin
                @(negedge clk);
                check_eq("rd_gap_ready", cresp.ready, 1'b0);
                check_eq("rd_rready", axi_req.rready, 1'b1);
                step();
            end
            axi_resp.rvalid = 1'b1;
            axi_resp.rdata  = base + 32'(i);
            axi_resp.rlast  = (i == int'(len));
            axi_resp.rresp  = rr;
            if (i == abort_beat) begin
                #2;
                resetn = 1'b0;
                #1;
                check_eq("rst_cresp", cresp, '0);
                check_eq("rst_valid_ready", valid_ready_bits(), 5'b0);
                check_eq("rst_bus_error", bus_error, 1'b0);
                check_eq("rst_state", dbg_state, ST_IDLE);
                axi_resp = '0;
                creq     = '0;
                exp_q.delete();
                exp_berr = 1'b0;
                step();
                step();
                resetn = 1'b1;
                return;
            end
            if (rr != 2'b00) exp_berr = 1'b1;
            @(negedge clk);
            check_eq("rd_beat_ready", cresp.ready, 1'b1);
            check_eq("rd_beat_last", cresp.last, (i == int'(len)));
            if (cresp.ready) sb_compare("rd_beat_data", cresp.data);
            step();
        end
        axi_resp.rvalid = 1'b0;
        axi_resp.rlast  = 1'b0;
        axi_resp.rresp  = 2'b00;
        creq.valid      = 1'b0;
        @(negedge clk);
        check_eq("rd_end_state", dbg_state, ST_IDLE);
        check_eq("rd_end_cresp", cresp, '0);
        check_eq("rd_bus_error", bus_error, exp_berr);
        step();
    endtask

    // ------------------------------------------------------------------
    // Driver: write burst (AW handshake, len+1 W beats, B response)
    // ------------------------------------------------------------------
    task automatic do_write(input logic [31:0] addr, input msize_t size, input logic [3:0] len,
                            input logic [3:0] strobe, input bit stalls, input logic [1:0] br);
        logic [31:0] wdat[16];
        int          stall;
        for (int i = 0; i <= int'(len); i++) begin
            wdat[i] = $urandom;
            exp_q.push_back(wdat[i]);
        end

        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = addr;
        creq.size     = size;
        creq.len      = mlen_t'(len);
        creq.strobe   = strobe;
        creq.data     = wdat[0];
        step();
        @(negedge clk);
        check_eq("wr_awvalid_lat", axi_req.awvalid, 1'b1);
        check_eq("wr_arvalid_quiet", axi_req.arvalid, 1'b0);
        check_eq("wr_awaddr", axi_req.awaddr, addr);
        check_eq("wr_awlen", axi_req.awlen, {4'b0, len});
        check_eq("wr_awsize", axi_req.awsize, size);
        check_eq("wr_awburst", axi_req.awburst, 2'b01);
        check_eq("wr_awid", axi_req.awid, 4'd0);

        stall = stalls ? $urandom_range(0, 2) : 0;
        for (int s = 0; s < stall; s++) begin
            step();
            @(negedge clk);
            check_eq("wr_awvalid_hold", axi_req.awvalid, 1'b1);
        end
        axi_resp.awready = 1'b1;
        step();
        axi_resp.awready = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            stall = stalls ? $urandom_range(0, 3) : 0;
            axi_resp.wready = 1'b0;
            for (int g = 0; g < stall; g++) begin
                @(negedge clk);
                check_eq("wr_stall_wvalid", axi_req.wvalid, 1'b1);
                check_eq("wr_stall_ready", cresp.ready, 1'b0);
                check_eq("wr_stall_wdata", axi_req.wdata, wdat[i]);
                step();
            end
            axi_resp.wready = 1'b1;
            @(negedge clk);
            check_eq("wr_wvalid", axi_req.wvalid, 1'b1);
            check_eq("wr_beat_ready", cresp.ready, 1'b1);
            check_eq("wr_beat_last", cresp.last, 1'b0);
            check_eq("wr_wlast", axi_req.wlast, (i == int'(len)));
            check_eq("wr_wstrb", axi_req.wstrb, strobe);
            if (axi_req.wvalid) sb_compare("wr_wdata", axi_req.wdata);
            step();
            if (i < int'(len)) creq.data = wdat[i+1];
        end
        axi_resp.wready = 1'b0;

        stall = stalls ? $urandom_range(0, 3) : 1;
        for (int g = 0; g < stall; g++) begin
            @(negedge clk);
            check_eq("wr_b_early_last", cresp.last, 1'b0);
            check_eq("wr_bready", axi_req.bready, 1'b1);
            check_eq("wr_b_wvalid", axi_req.wvalid, 1'b0);
            step();
        end
        axi_resp.bvalid = 1'b1;
        axi_resp.bresp  = br;
        if (br != 2'b00) exp_berr = 1'b1;
        @(negedge clk);
        check_eq("wr_done_last", cresp.last, 1'b1);
        check_eq("wr_done_ready", cresp.ready, 1'b0);
        step();
        axi_resp.bvalid = 1'b0;
        axi_resp.bresp  = 2'b00;
        creq.valid      = 1'b0;
        @(negedge clk);
        check_eq("wr_end_state", dbg_state, ST_IDLE);
        check_eq("wr_bus_error", bus_error, exp_berr);
        step();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        resetn   = 1'b0;
        creq     = '0;
        axi_resp = '0;
        exp_berr = 1'b0;
        #3;
        check_eq("reset_cresp", cresp, '0);
        check_eq("reset_valid_ready", valid_ready_bits(), 5'b0);
        check_eq("reset_bus_error", bus_error, 1'b0);
        check_eq("reset_state", dbg_state, ST_IDLE);
        step();
        step();
        resetn = 1'b1;
        step();

        // Single-word read.
        do_read(32'h1FC0_0004, MSIZE4, 4'd0, 32'hDEAD_BEEF, 1'b0, 2'b00, -1);
        // 16-beat line fill with random rvalid gaps, rdata = beat index.
        do_read(32'h8000_0100, MSIZE4, 4'd15, 32'd0, 1'b1, 2'b00, -1);
        // 16-beat write-back with random wready stalls.
        do_write(32'h8000_0200, MSIZE4, 4'd15, 4'hF, 1'b1, 2'b00);
        // Uncached byte store.
        do_write(32'hBFAF_0003, MSIZE1, 4'd0, 4'b1000, 1'b0, 2'b00);
        // SLVERR on a write, then a clean read: bus_error sticks.
        do_write(32'h0000_1000, MSIZE4, 4'd3, 4'hF, 1'b1, 2'b10);
        do_read(32'h0000_2000, MSIZE4, 4'd3, 32'h1234_0000, 1'b1, 2'b00, -1);
        // Reset during beat 7 of a fill, then a fresh read.
        do_read(32'h8000_0300, MSIZE4, 4'd15, 32'd0, 1'b0, 2'b00, 7);
        do_read(32'h8000_0400, MSIZE4, 4'd0, 32'hCAFE_F00D, 1'b0, 2'b00, -1);
        // A few random mixed transactions.
        for (int t = 0; t < 4; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write({$urandom_range(0, 32'hFFFF), 16'h0}, MSIZE4,
                         4'($urandom_range(0, 15)), 4'hF, 1'b1, 2'b00);
            else
                do_read({$urandom_range(0, 32'hFFFF), 16'h0}, MSIZE4,
                        4'($urandom_range(0, 15)), $urandom, 1'b1, 2'b00, -1);
        end

        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
